// File: rtl/controlador_interrupciones_pkg.sv
// Shared types for the priority interrupt controller: FSM states and the
// lowest-set-bit priority encoder used for both request selection and reti.
package controlador_interrupciones_pkg;

  localparam int MAX_IRQ = 4;  // irq_id is 2 bits wide, so at most 4 lines
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} estado_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] idx;
  } sel_t;

  // Lowest index wins, so line 0 has the highest priority.
  function automatic sel_t prioridad(input logic [MAX_IRQ-1:0] req);
    sel_t s;
    s = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        s.valid = 1'b1;
        s.idx   = ID_W'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/controlador_interrupciones_detector_flancos.sv
// Per-line rising-edge detector with a sticky pending flop; a new edge
// beats a same-cycle acknowledge clear so no request is lost.
module detector_flancos (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic clr,
  output logic pending
);

  logic prev_q, prev_d;
  logic pend_q, pend_d;

  always_comb begin
    prev_d = din;
    pend_d = pend_q;
    if (clr)           pend_d = 1'b0;
    if (din && !prev_q) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/controlador_interrupciones.sv
// Priority interrupt controller with req/ack handshake to the control unit.
// Define INTC_NESTING_EN to let higher-priority lines preempt an active handler.
module controlador_interrupciones
  import controlador_interrupciones_pkg::*;
#(
  parameter int               NUM_IRQ  = 3,
  parameter int               VEC_W    = 10,
  parameter logic [VEC_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] interrupciones,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               inst_boundary,
  input  logic               irq_ack,
  input  logic               reti,
  output logic               irq,
  output logic [VEC_W-1:0]   vector,
  output logic [1:0]         irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);

  estado_e             state_q, state_d;
  logic [ID_W-1:0]     irq_id_q, irq_id_d;
  logic [VEC_W-1:0]    vector_q, vector_d;
  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic [NUM_IRQ-1:0]  in_service_q, in_service_d;
  logic [NUM_IRQ-1:0]  clr, pend, elig;
  sel_t                sel_elig, sel_svc;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    detector_flancos u_det (
      .clk     (clk),
      .reset   (reset),
      .din     (interrupciones[i]),
      .clr     (clr[i]),
      .pending (pend[i])
    );
  end

  assign sel_svc = prioridad(MAX_IRQ'(in_service_q));

  always_comb begin
    elig = pend & mask_q;
`ifdef INTC_NESTING_EN
    // Only lines strictly above the most urgent active handler may preempt.
    if (state_q == SERVICE) begin
      for (int j = 0; j < NUM_IRQ; j++)
        if (j >= int'(sel_svc.idx)) elig[j] = 1'b0;
    end
`endif
  end

  assign sel_elig = prioridad(MAX_IRQ'(elig));

  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;
    clr          = '0;
    mask_d       = mask_we ? mask_in : mask_q;
    case (state_q)
      IDLE: begin
        if (inst_boundary && sel_elig.valid) begin
          state_d  = REQ;
          irq_id_d = sel_elig.idx;
          vector_d = VEC_BASE + VEC_W'(sel_elig.idx);
        end
      end
      REQ: begin
        if (irq_ack) begin
          clr[irq_id_q]          = 1'b1;
          in_service_d[irq_id_q] = 1'b1;
          state_d                = SERVICE;
        end
      end
      SERVICE: begin
        if (reti) begin
          if (sel_svc.valid) in_service_d[sel_svc.idx] = 1'b0;
          if (in_service_d == '0) state_d = IDLE;
        end
`ifdef INTC_NESTING_EN
        else if (inst_boundary && sel_elig.valid) begin
          state_d  = REQ;
          irq_id_d = sel_elig.idx;
          vector_d = VEC_BASE + VEC_W'(sel_elig.idx);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      irq_id_q     <= '0;
      vector_q     <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      vector_q     <= vector_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
    end
  end

  assign irq        = (state_q == REQ);
  assign vector     = vector_q;
  assign irq_id     = irq_id_q;
  assign pending    = pend;
  assign in_service = in_service_q;

endmodule
